// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the burst master that drives the single-port
// synchronous word memory (registered read data, one cycle latency).
//
// Contents:
//   WORD_DEF / ADDR_DEF / LEN_W_DEF : default data, address and burst length
//                                     field widths
//   RD_BUF_DEPTH / RD_CNT_W         : depth of the read response buffer and
//                                     the width of its occupancy count
//   burst_state_e                   : burst master FSM states
//   rdCreditOk()                    : read issue credit check
// ---------------------------------------------------------------------------
package mem_if_pkg;

    localparam int WORD_DEF     = 32;
    localparam int ADDR_DEF     = 16;
    localparam int LEN_W_DEF    = 8;

    localparam int RD_BUF_DEPTH = 2;
    localparam int RD_CNT_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } burst_state_e;

    // A new read may only be issued if, after this cycle's pop, the words
    // already buffered plus the word still coming back from the memory leave
    // room for it. Counting the in-flight word is what keeps a stalled client
    // from causing the buffer to overflow.
    function automatic logic rdCreditOk(
        input logic [RD_CNT_W-1:0] bufCount,
        input logic                inflight,
        input logic                pop
    );
        int used;
        used = int'(bufCount) + int'(inflight) - int'(pop);
        return (used < RD_BUF_DEPTH);
    endfunction

endpackage

// File: rtl/mem_rd_skid.sv
// ---------------------------------------------------------------------------
// mem_rd_skid
// Two-entry FIFO carrying a data word plus a "last" marker. Used to catch the
// fixed-latency response of a memory (or any similar responder) so that the
// consumer can apply backpressure without losing words already requested.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (empties the FIFO)
//   push_i            write pushData_i/pushLast_i into the tail
//   pushData_i        payload word
//   pushLast_i        payload last marker
//   pop_i             remove the head entry (ignored when empty)
//   headData_o        head payload word (valid when count_o != 0)
//   headLast_o        head last marker  (valid when count_o != 0)
//   count_o           number of occupied entries, 0..2
// ---------------------------------------------------------------------------
module mem_rd_skid
    import mem_if_pkg::*;
#(
    parameter int WIDTH = WORD_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic [WIDTH-1:0]    pushData_i,
    input  logic                pushLast_i,
    input  logic                pop_i,
    output logic [WIDTH-1:0]    headData_o,
    output logic                headLast_o,
    output logic [RD_CNT_W-1:0] count_o
);

    logic [WIDTH-1:0]    data_q [RD_BUF_DEPTH];
    logic                last_q [RD_BUF_DEPTH];

    logic                wrPtr_q;
    logic                wrPtr_d;
    logic                rdPtr_q;
    logic                rdPtr_d;
    logic [RD_CNT_W-1:0] count_q;
    logic [RD_CNT_W-1:0] count_d;

    logic                popEff;
    logic                pushEff;

    // A full FIFO still accepts a push in the same cycle as a pop, since the
    // head slot frees up at the same edge. With only two slots the pointers
    // are single bits that simply toggle.
    always_comb begin
        popEff  = pop_i && (count_q != '0);
        pushEff = push_i && ((count_q != RD_CNT_W'(RD_BUF_DEPTH)) || popEff);
        wrPtr_d = wrPtr_q ^ pushEff;
        rdPtr_d = rdPtr_q ^ popEff;
        count_d = count_q + RD_CNT_W'(pushEff) - RD_CNT_W'(popEff);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: the occupancy count decides what is valid.
    always_ff @(posedge clk) begin
        if (pushEff) begin
            data_q[wrPtr_q] <= pushData_i;
            last_q[wrPtr_q] <= pushLast_i;
        end
    end

    assign headData_o = data_q[rdPtr_q];
    assign headLast_o = last_q[rdPtr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/mem_burst_master.sv
// ---------------------------------------------------------------------------
// mem_burst_master
// Burst initiator for a single-port synchronous word memory. Turns
// valid/ready burst requests into cycle-accurate memory address, write
// enable and write data, and returns read data as a backpressurable stream.
// One burst is handled at a time.
//
// Ports:
//   clk, rst_n          clock shared with the memory; synchronous active-low
//                       reset that abandons any burst in progress
//   req_valid/req_ready burst request handshake
//   req_write           1 = write burst, 0 = read burst
//   req_addr            first word address
//   req_len             number of beats minus one
//   wr_valid/wr_ready   write beat handshake, wr_data is the beat payload
//   rd_valid/rd_ready   read beat handshake, rd_data is the beat payload,
//                       rd_last flags the final beat of the burst
//   mem_A, mem_W, mem_D memory address, write enable, write data
//   mem_Q               memory read data, registered one cycle after mem_A
// ---------------------------------------------------------------------------
module mem_burst_master
    import mem_if_pkg::*;
#(
    parameter int WORD  = WORD_DEF,
    parameter int ADDR  = ADDR_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [ADDR-1:0]  req_addr,
    input  logic [LEN_W-1:0] req_len,

    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WORD-1:0]  wr_data,

    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WORD-1:0]  rd_data,
    output logic             rd_last,

    output logic [ADDR-1:0]  mem_A,
    output logic             mem_W,
    output logic [WORD-1:0]  mem_D,
    input  logic [WORD-1:0]  mem_Q
);

    burst_state_e        state_q;
    burst_state_e        state_d;
    logic [ADDR-1:0]     curAddr_q;
    logic [ADDR-1:0]     curAddr_d;
    logic [LEN_W-1:0]    wrLeft_q;
    logic [LEN_W-1:0]    wrLeft_d;
    logic [LEN_W:0]      issueLeft_q;
    logic [LEN_W:0]      issueLeft_d;
    logic                inflight_q;
    logic                inflight_d;
    logic                inflightLast_q;
    logic                inflightLast_d;
    logic [ADDR-1:0]     lastA_q;
    logic [ADDR-1:0]     lastA_d;

    logic                writeBeat;
    logic                wrReadyRaw;
    logic                pop;
    logic [RD_CNT_W-1:0] bufCount;
    logic [WORD-1:0]     headData;
    logic                headLast;

    // Read response buffer. Whatever was issued last cycle is on mem_Q now
    // and is captured unconditionally; the credit check guarantees space.
    mem_rd_skid #(
        .WIDTH (WORD)
    ) u_rdSkid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .pushData_i (mem_Q),
        .pushLast_i (inflightLast_q),
        .pop_i      (pop),
        .headData_o (headData),
        .headLast_o (headLast),
        .count_o    (bufCount)
    );

    assign rd_valid = (bufCount != '0);
    assign rd_data  = headData;
    assign rd_last  = rd_valid && headLast;
    assign pop      = rd_valid && rd_ready;

    // Write data is passed straight through; it only matters while mem_W=1.
    assign mem_D    = wr_data;

    // Write enable and write-ready are gated with reset so that nothing is
    // accepted or written during the reset cycle itself.
    assign mem_W    = writeBeat && rst_n;
    assign wr_ready = wrReadyRaw && rst_n;

    // Next-state and output decode. The memory address is taken straight
    // from curAddr_q when a beat is written or a read is issued; otherwise
    // it shows the last address driven so the memory port does not toggle
    // while idle or stalled.
    always_comb begin
        state_d        = state_q;
        curAddr_d      = curAddr_q;
        wrLeft_d       = wrLeft_q;
        issueLeft_d    = issueLeft_q;
        inflight_d     = 1'b0;
        inflightLast_d = 1'b0;
        lastA_d        = lastA_q;
        mem_A          = lastA_q;
        req_ready      = 1'b0;
        wrReadyRaw     = 1'b0;
        writeBeat      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    curAddr_d   = req_addr;
                    wrLeft_d    = req_len;
                    issueLeft_d = {1'b0, req_len} + {{LEN_W{1'b0}}, 1'b1};
                    state_d     = req_write ? ST_WRITE : ST_READ;
                end
            end

            ST_WRITE: begin
                wrReadyRaw = 1'b1;
                if (wr_valid) begin
                    writeBeat = 1'b1;
                    mem_A     = curAddr_q;
                    lastA_d   = curAddr_q;
                    curAddr_d = curAddr_q + ADDR'(1);
                    wrLeft_d  = wrLeft_q - LEN_W'(1);
                    if (wrLeft_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_READ: begin
                if ((issueLeft_q != '0) && rdCreditOk(bufCount, inflight_q, pop)) begin
                    mem_A          = curAddr_q;
                    lastA_d        = curAddr_q;
                    curAddr_d      = curAddr_q + ADDR'(1);
                    issueLeft_d    = issueLeft_q - {{LEN_W{1'b0}}, 1'b1};
                    inflight_d     = 1'b1;
                    inflightLast_d = (issueLeft_q == {{LEN_W{1'b0}}, 1'b1});
                end
                if (pop && rd_last) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset abandons the burst: the in-flight read is
    // forgotten so its data is never pushed into the (also cleared) buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            curAddr_q      <= '0;
            wrLeft_q       <= '0;
            issueLeft_q    <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            lastA_q        <= '0;
        end else begin
            state_q        <= state_d;
            curAddr_q      <= curAddr_d;
            wrLeft_q       <= wrLeft_d;
            issueLeft_q    <= issueLeft_d;
            inflight_q     <= inflight_d;
            inflightLast_q <= inflightLast_d;
            lastA_q        <= lastA_d;
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_master
// Self-checking bench for mem_burst_master with a behavioural model of the
// single-port memory. Expected writes and read beats are queued when the
// stimulus is driven and compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_mem_burst_master;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wrExp_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } rdExp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic [15:0] mem_A;
    logic        mem_W;
    logic [31:0] mem_D;
    logic [31:0] mem_Q;

    logic [31:0] tbMem  [0:65535];
    logic [31:0] refMem [0:65535];

    wrExp_t expWrite [$];
    rdExp_t expRead  [$];

    int   assertCount = 0;
    int   failCount   = 0;
    logic monitorOn   = 1'b0;

    mem_burst_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .mem_A     (mem_A),
        .mem_W     (mem_W),
        .mem_D     (mem_D),
        .mem_Q     (mem_Q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: write at the edge, read data registered one cycle later.
    always @(posedge clk) begin
        if (mem_W) tbMem[mem_A] <= mem_D;
        mem_Q <= tbMem[mem_A];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compares every memory write and every accepted read beat against the
    // scoreboard queues.
    initial begin
        wrExp_t we;
        rdExp_t re;
        forever begin
            @(negedge clk);
            #2;
            if (monitorOn) begin
                if (mem_W) begin
                    if (expWrite.size() == 0) begin
                        checkOutput("unexpectedWrite", 64'(mem_A), 64'hFFFF_FFFF);
                    end else begin
                        we = expWrite.pop_front();
                        checkOutput("wrAddr", 64'(mem_A), 64'(we.addr));
                        checkOutput("wrData", 64'(mem_D), 64'(we.data));
                    end
                end
                if (rd_valid && rd_ready) begin
                    if (expRead.size() == 0) begin
                        checkOutput("unexpectedRead", 64'(rd_data), 64'hFFFF_FFFF);
                    end else begin
                        re = expRead.pop_front();
                        checkOutput("rdData", 64'(rd_data), 64'(re.data));
                        checkOutput("rdLast", 64'(rd_last), 64'(re.last));
                    end
                end
            end
        end
    end

    // Presents a request and returns at the falling edge just after the
    // accepting clock edge.
    task automatic requestBurst(input logic isWrite, input logic [15:0] addr,
                                input logic [7:0] len);
        int   waitCyc;
        logic accepted;
        waitCyc  = 0;
        accepted = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = isWrite;
        req_addr  = addr;
        req_len   = len;
        while (!accepted && waitCyc < 50) begin
            #1;
            if (req_ready) accepted = 1'b1;
            @(negedge clk);
            waitCyc++;
        end
        req_valid = 1'b0;
        if (!accepted) checkOutput("reqTimeout", 64'd0, 64'd1);
    endtask

    task automatic writeBurst(input logic [15:0] addr, input logic [7:0] len,
                              input logic [31:0] base, input logic [7:0] validMask);
        int          beat;
        int          cyc;
        logic [15:0] a;
        wrExp_t      e;
        requestBurst(1'b1, addr, len);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 64) begin
            wr_valid = validMask[cyc % 8];
            wr_data  = base + 32'(beat);
            #1;
            checkOutput("wrReady", 64'(wr_ready), 64'd1);
            checkOutput("memWFollowsValid", 64'(mem_W), 64'(wr_valid));
            if (wr_valid && wr_ready) begin
                a      = addr + 16'(beat);
                e.addr = a;
                e.data = wr_data;
                expWrite.push_back(e);
                refMem[a] = wr_data;
                beat++;
            end
            cyc++;
            @(negedge clk);
        end
        if (beat <= int'(len)) checkOutput("writeTimeout", 64'd0, 64'd1);
        wr_valid = 1'b0;
        #1;
        checkOutput("reqReadyAfterWrite", 64'(req_ready), 64'd1);
    endtask

    // readyMode 0: rd_ready held high; 1: rd_ready pattern 1,0,0 repeating.
    // stopAfter != 0 returns after that many beats without finishing.
    task automatic readBurst(input logic [15:0] addr, input logic [7:0] len,
                             input int readyMode, input int stopAfter, input logic checkLat);
        int          cyc;
        int          pops;
        int          firstValid;
        int          firstPop;
        int          lastPop;
        logic        done;
        logic [15:0] a;
        rdExp_t      e;
        for (int i = 0; i <= int'(len); i++) begin
            a      = addr + 16'(i);
            e.data = refMem[a];
            e.last = (i == int'(len));
            expRead.push_back(e);
        end
        requestBurst(1'b0, addr, len);
        cyc        = 0;
        pops       = 0;
        firstValid = -1;
        firstPop   = -1;
        lastPop    = -1;
        done       = 1'b0;
        while (!done && cyc < 300) begin
            rd_ready = (readyMode == 0) ? 1'b1 : ((cyc % 3) == 0);
            #2;
            if (rd_valid && firstValid < 0) firstValid = cyc;
            if (rd_valid && rd_ready) begin
                pops++;
                if (firstPop < 0) firstPop = cyc;
                lastPop = cyc;
                if (rd_last) done = 1'b1;
                if (stopAfter != 0 && pops == stopAfter) done = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        if (!done) checkOutput("readTimeout", 64'd0, 64'd1);
        if (checkLat) begin
            checkOutput("rdLatency", 64'(firstValid), 64'd2);
            checkOutput("rdBackToBack", 64'(lastPop - firstPop), 64'(len));
        end
        checkOutput("rdBeatCount", 64'(pops), (stopAfter != 0) ? 64'(stopAfter) : 64'(int'(len) + 1));
        if (stopAfter == 0) begin
            #2;
            checkOutput("reqReadyAfterRead", 64'(req_ready), 64'd1);
        end
    endtask

    task automatic applyStimulus();
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("rstReqReady", 64'(req_ready), 64'd1);
        checkOutput("rstWrReady",  64'(wr_ready),  64'd0);
        checkOutput("rstRdValid",  64'(rd_valid),  64'd0);
        checkOutput("rstRdLast",   64'(rd_last),   64'd0);
        checkOutput("rstMemW",     64'(mem_W),     64'd0);
        checkOutput("rstMemA",     64'(mem_A),     64'd0);
        monitorOn = 1'b1;

        // Continuous write burst, then the address port holds the last address
        writeBurst(16'h0010, 8'd3, 32'h0000_00A0, 8'hFF);
        checkOutput("memAHold", 64'(mem_A), 64'h13);

        // Read it back at full rate
        readBurst(16'h0010, 8'd3, 0, 0, 1'b1);

        // Long read with a stalling client
        readBurst(16'h0000, 8'd7, 1, 0, 1'b0);

        // Address wrap on write, then read across the wrap
        writeBurst(16'hFFFF, 8'd1, 32'h0000_00B0, 8'hFF);
        readBurst(16'hFFFF, 8'd1, 0, 0, 1'b1);

        // Reset in the middle of a six-beat read
        readBurst(16'h0020, 8'd5, 0, 2, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expRead.delete();
        #2;
        checkOutput("midRstRdValid",  64'(rd_valid),  64'd0);
        checkOutput("midRstMemW",     64'(mem_W),     64'd0);
        checkOutput("midRstReqReady", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd_ready = 1'b1;
            #2;
            checkOutput("noBeatAfterRst", 64'(rd_valid), 64'd0);
        end
        rd_ready = 1'b0;
        readBurst(16'h0011, 8'd0, 0, 0, 1'b1);

        // Write with wr_valid gaps 1,0,1,0,1 then read the three words back
        writeBurst(16'h0040, 8'd2, 32'h0000_00C0, 8'b0101_0101);
        readBurst(16'h0040, 8'd2, 0, 0, 1'b1);

        repeat (3) @(negedge clk);
        checkOutput("wrQueueDrained", 64'(expWrite.size()), 64'd0);
        checkOutput("rdQueueDrained", 64'(expRead.size()),  64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            tbMem[i]  = {16'h5A5A, 16'(i)};
            refMem[i] = {16'h5A5A, 16'(i)};
        end
        $display("[TB] starting mem_burst_master bench");
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Initiator for the single-port synchronous word memory (32-bit words, 16-bit address, registered read data one cycle after address). It turns valid/ready burst requests into cycle-accurate memory address, write-enable and data drive. It also collects the memory's read output into a backpressurable response stream. It sits between any client (CPU load/store unit, DMA, testbench driver) and the memory's A/W/D/Q port.

## Interface
- WORD, 32, data width; equals memory word width
- ADDR, 16, address width; equals memory address width
- LEN_W, 8, burst length field width; bursts of 1..2^LEN_W beats
- clk  in  1  rising-edge clock, shared with the memory
- rst_n  in  1  reset; one clock, synchronous and active-low
- req_valid  in  1  burst request valid
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR  first word address
- req_len  in  LEN_W  beats minus one
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write beat accepted when valid&ready
- wr_data  in  WORD  write beat data
- rd_valid  out  1  read beat valid
- rd_ready  in  1  client accepts read beat
- rd_data  out  WORD  read beat data
- rd_last  out  1  marks final beat of a read burst
- mem_A  out  ADDR  memory address
- mem_W  out  1  memory write enable
- mem_D  out  WORD  memory write data
- mem_Q  in  WORD  memory registered read data

## Operation
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, len and direction, then go to WRITE or READ.
  - One burst in flight at a time.
- WRITE:
  - wr_ready=1.
  - Each cycle with wr_valid: mem_W=1, mem_A=cur_addr, mem_D=wr_data; then cur_addr+1 and count-1.
  - After the beat with count==0, go to IDLE.
  - A wr_valid gap leaves mem_W=0 for that cycle.
- READ:
  - Issue a read (mem_W=0, mem_A=cur_addr) when beats remain to issue and (buf_count + inflight − pop) < 2. pop = rd_valid&rd_ready.
  - On issue: inflight is set for the next cycle, and cur_addr increments.
  - The cycle after issue, push mem_Q into the 2-entry read buffer.
  - rd_valid = buffer non-empty.
  - rd_last = 1 on the buffer head for the final beat.
  - Go to IDLE when the last beat pops.
- Address increments wrap modulo 2^ADDR, so 0xFFFF is followed by 0x0000.
- mem_W is never 1 outside WRITE and is gated with rst_n.
- mem_A holds its last value when idle. mem_D is don't-care unless mem_W=1.
- Writes and reads never mix within a burst. Write data goes to the memory in order with no buffering.

## Timing
- Reset (rst_n low at an edge):
  - State returns to IDLE; buffer and inflight clear; cur_addr=0.
  - Outputs: req_ready=1, wr_ready=0, rd_valid=0, rd_last=0, mem_W=0, mem_A=0.
  - Reset mid-burst abandons the burst. Partially written words stay written; no read beats are emitted after reset.
- Write latency: a beat accepted at edge T is written at edge T; wr_ready and mem_W are combinational from state and wr_valid.
- Read latency: request accepted at edge T0 → first issue in cycle T0..T1 → mem_Q valid after T1 → buffered at T2. rd_valid is high from T2, i.e. 2 cycles after accept.
- Throughput with rd_ready held 1: one beat per cycle, no bubbles.
- rd_ready low: the buffer fills to 2 entries and issue stops. No read data is lost, because inflight is counted in the credit.
- Back-to-back bursts: req_ready returns in the cycle after the final write beat or final read pop.

## Structure
- Package mem_if_pkg holds:
  - the FSM state enum;
  - default WORD/ADDR/LEN_W localparams;
  - the buffer depth constant (2).
- Sub-module mem_rd_skid: a 2-entry FIFO with a data+last payload, push/pop, and count out. It is reused for any fixed-latency responder.

## Test plan
- Write burst addr=0x0010, len=3, data 0xA0..0xA3 with wr_valid always 1 → mem_W=1 four consecutive cycles with mem_A 0x10..0x13; then req_ready=1.
- Read back the same burst with rd_ready=1 → rd_valid 2 cycles after accept; rd_data A0,A1,A2,A3 on consecutive cycles; rd_last only on A3.
- Read len=7 from 0x0000 with rd_ready toggling 1,0,0,1… → all 8 beats delivered in order; mem issue never exceeds buffer credit; no duplicates.
- Write len=1 at 0xFFFF → writes hit 0xFFFF then 0x0000 (wrap).
- Assert rst_n=0 mid read burst after 2 of 6 beats → next cycle rd_valid=0, mem_W=0, req_ready=1; a new read of len=0 then returns the correct word.
- Write burst with wr_valid gaps (1,0,1,0,1) → mem_W follows wr_valid; 3 words written at consecutive addresses.
